// File: rtl/fir_pkg.sv
// Shared types and helpers for the parametrised time-multiplexed FIR filter.
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } fir_state_e;

    // Accumulator width: full product plus growth for summing TAPS products.
    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                    input int              out_w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (v > max_v) begin
            return max_v;
        end else if (v < min_v) begin
            return min_v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/fir_filter_param_if.sv
// Sample, result and coefficient-write handshakes of the FIR filter core.
interface fir_filter_param_if #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 8,
    parameter int ADDR_W = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     coef_we;
    logic [ADDR_W-1:0]        coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic                     coef_ready;

    modport master (
        output in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        input  in_ready, out_valid, out_data, coef_ready
    );

    modport slave (
        input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_data,
        output in_ready, out_valid, out_data, coef_ready
    );
endinterface

// File: rtl/fir_mac.sv
// Registered signed multiply-accumulate shared by all taps of the FIR filter.
module fir_mac #(
    parameter int A_W   = 8,
    parameter int B_W   = 8,
    parameter int ACC_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    en,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    output logic signed [ACC_W-1:0] acc
);
    logic signed [A_W+B_W-1:0] prod_s;
    logic signed [ACC_W-1:0]   acc_r;

    assign prod_s = a * b;
    assign acc    = acc_r;

    // Accumulator: cleared at the start of each sample, sign-extended product added per tap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= acc_r + ACC_W'(prod_s);
        end
    end
endmodule

// File: rtl/fir_filter_param.sv
// Time-multiplexed FIR filter: one MAC reused over TAPS cycles per sample.
// Optional FIR_SATURATE_EN clamps the output instead of wrapping it.
module fir_filter_param
    import fir_pkg::*;
#(
    parameter int TAPS      = 4,
    parameter int DATA_W    = 8,
    parameter int COEF_W    = 8,
    parameter int OUT_W     = 8,
    parameter int OUT_SHIFT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    fir_filter_param_if.slave   bus
);
    localparam int ADDR_W = $clog2(TAPS);
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);

    fir_state_e               state_r;
    fir_state_e               state_nxt_s;
    logic [ADDR_W-1:0]        idx_r;
    logic signed [DATA_W-1:0] x_r    [TAPS];
    logic signed [COEF_W-1:0] coef_r [TAPS];
    logic signed [DATA_W-1:0] mac_a_s;
    logic signed [COEF_W-1:0] mac_b_s;
    logic signed [ACC_W-1:0]  acc_s;
    logic signed [ACC_W-1:0]  shifted_s;
    logic signed [OUT_W-1:0]  result_s;
    logic signed [OUT_W-1:0]  out_data_r;
    logic                     out_valid_r;
    logic                     idle_s;
    logic                     last_s;
    logic                     addr_ok_s;
    logic                     coef_wr_s;
    logic                     accept_s;
    logic                     mac_clr_s;
    logic                     mac_en_s;
    logic                     out_load_s;
    logic                     out_clear_s;

    assign idle_s         = ena && rst_n && (state_r == IDLE);
    assign bus.in_ready   = idle_s;
    assign bus.coef_ready = idle_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_data   = out_data_r;

    assign last_s  = (idx_r == ADDR_W'(TAPS - 1));
    assign mac_a_s = x_r[idx_r];
    assign mac_b_s = coef_r[idx_r];

    // Out-of-range tap indices only exist when TAPS is not a power of two.
    if ((2 ** ADDR_W) > TAPS) begin : g_addr_chk
        assign addr_ok_s = (bus.coef_addr < ADDR_W'(TAPS));
    end else begin : g_addr_all
        assign addr_ok_s = 1'b1;
    end

    assign coef_wr_s = idle_s && bus.coef_we && addr_ok_s;

    assign shifted_s = acc_s >>> OUT_SHIFT;
`ifdef FIR_SATURATE_EN
    assign result_s = OUT_W'(saturate(64'(shifted_s), OUT_W));
`else
    assign result_s = OUT_W'(shifted_s);
`endif

    fir_mac #(
        .A_W   (DATA_W),
        .B_W   (COEF_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mac_clr_s),
        .en    (mac_en_s),
        .a     (mac_a_s),
        .b     (mac_b_s),
        .acc   (acc_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath strobes; everything idles while ena is low.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        mac_clr_s   = 1'b0;
        mac_en_s    = 1'b0;
        out_load_s  = 1'b0;
        out_clear_s = 1'b0;
        if (ena) begin
            case (state_r)
                IDLE: begin
                    if (bus.in_valid) begin
                        accept_s    = 1'b1;
                        mac_clr_s   = 1'b1;
                        state_nxt_s = MAC;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                MAC: begin
                    mac_en_s = 1'b1;
                    if (last_s) begin
                        state_nxt_s = OUT;
                    end else begin
                        state_nxt_s = MAC;
                    end
                end
                OUT: begin
                    // First OUT cycle registers the result; later cycles wait for the consumer.
                    if (!out_valid_r) begin
                        out_load_s = 1'b1;
                    end else if (bus.out_ready) begin
                        out_clear_s = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = OUT;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Delay line, coefficient file, tap index and registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_r[k]    <= '0;
                coef_r[k] <= '0;
            end
            coef_r[0]   <= COEF_W'(1);
            idx_r       <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else begin
            if (coef_wr_s) begin
                coef_r[bus.coef_addr] <= bus.coef_data;
            end
            if (accept_s) begin
                for (int k = TAPS - 1; k > 0; k--) begin
                    x_r[k] <= x_r[k-1];
                end
                x_r[0] <= bus.in_data;
                idx_r  <= '0;
            end
            if (mac_en_s) begin
                idx_r <= last_s ? '0 : idx_r + ADDR_W'(1);
            end
            if (out_load_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= result_s;
            end
            if (out_clear_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fir_filter_param.sv
// Self-checking bench for fir_filter_param (TAPS=4, 8-bit data/coef/out, no shift).
module tb_fir_filter_param;
    localparam int TAPS      = 4;
    localparam int OUT_SHIFT = 0;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;

    always #5 clk = ~clk;

    fir_filter_param_if #(.DATA_W(8), .COEF_W(8), .OUT_W(8), .ADDR_W(2)) bus ();

    fir_filter_param #(
        .TAPS(TAPS), .DATA_W(8), .COEF_W(8), .OUT_W(8), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .bus   (bus)
    );

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         accept_cyc = 0;
    int         mx [TAPS];
    int         mc [TAPS];
    logic [7:0] exp_q [$];
    logic [7:0] d;
    int         lat;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference result: plain convolution of the model delay line with the model coefficients.
    function automatic logic [7:0] model_out();
        longint s;
        s = 0;
        for (int k = 0; k < TAPS; k++) s += longint'(mx[k]) * longint'(mc[k]);
        s = s >>> OUT_SHIFT;
`ifdef FIR_SATURATE_EN
        if (s > 127) s = 127;
        else if (s < -128) s = -128;
`endif
        return s[7:0];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            mx[k] = 0;
            mc[k] = 0;
        end
        mc[0] = 1;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic send(input int v);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'(v);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                ok = 1'b1;
                accept_cyc = cyc;
            end
            @(posedge clk);
            if (ok) begin
                for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
                mx[0] = v;
                exp_q.push_back(model_out());
            end
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic wcoef(input int a, input int v);
        bit ok;
        ok = 1'b0;
        bus.coef_we   = 1'b1;
        bus.coef_addr = 2'(a);
        bus.coef_data = 8'(v);
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.coef_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            if (ok) mc[a] = v;
            #1;
        end
        bus.coef_we = 1'b0;
        if (!ok) check("coef_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_out(output logic [7:0] dv, output int lv);
        bit found;
        found = 1'b0;
        dv = 8'd0;
        lv = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                found = 1'b1;
                dv = bus.out_data;
                lv = cyc - accept_cyc - 1;
            end
        end
        if (!found) check("out_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 100 && !empty; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) empty = 1'b1;
        end
        if (!empty) check("drain_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every cycle with out_valid high must show the oldest pending model result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(bus.out_valid), 64'd0);
            end else begin
                check("out_data", 64'(8'(bus.out_data)), 64'(exp_q[0]));
                if (bus.out_ready === 1'b1 && ena === 1'b1) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        ena = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = 8'd0;
        bus.out_ready = 1'b1;
        bus.coef_we = 1'b0;
        bus.coef_addr = 2'd0;
        bus.coef_data = 8'd0;
        model_reset();

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(8'(bus.out_data)), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_coef_ready", 64'(bus.coef_ready), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: identity coefficients pass the sample through, latency TAPS+1
        send(5);
        wait_out(d, lat);
        check("t1_data", 64'(d), 64'd5);
        check("t1_latency", 64'(lat), 64'd5);
        drain();

        // 2: impulse response reproduces the coefficients
        do_reset();
        for (int k = 0; k < TAPS; k++) wcoef(k, k + 1);
        for (int i = 0; i < 5; i++) begin
            send(i == 0 ? 1 : 0);
            wait_out(d, lat);
            check("t2_impulse", 64'(d), (i < 4) ? 64'(i + 1) : 64'd0);
            drain();
        end

        // 3: back-pressure holds the result; samples offered meanwhile are refused
        bus.out_ready = 1'b0;
        send(9);
        wait_out(d, lat);
        check("t3_data", 64'(d), 64'd9);
        bus.in_valid = 1'b1;
        bus.in_data = 8'd55;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(bus.out_valid), 64'd1);
            check("t3_hold_data", 64'(8'(bus.out_data)), 64'd9);
            check("t3_in_ready", 64'(bus.in_ready), 64'd0);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        drain();
        send(0);
        wait_out(d, lat);
        check("t3_after", 64'(d), 64'd18);
        drain();

        // 4: full-scale inputs and coefficients overflow the output width
        for (int k = 0; k < TAPS; k++) wcoef(k, 127);
        for (int i = 0; i < 4; i++) begin
            send(127);
            wait_out(d, lat);
            drain();
        end
`ifdef FIR_SATURATE_EN
        check("t4_full_scale", 64'(d), 64'h7f);
`else
        check("t4_full_scale", 64'(d), 64'h04);
`endif

        // 5: reset in the middle of MAC aborts the sample and clears the delay line
        send(3);
        @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_rst_valid", 64'(bus.out_valid), 64'd0);
        check("t5_rst_in_ready", 64'(bus.in_ready), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < TAPS; k++) wcoef(k, 1);
        send(7);
        wait_out(d, lat);
        check("t5_clean", 64'(d), 64'd7);
        drain();

        // 6: coefficient writes refused during MAC; ena low stretches latency only
        wcoef(1, 3);
        send(10);
        bus.coef_we = 1'b1;
        bus.coef_addr = 2'd0;
        bus.coef_data = 8'd50;
        @(negedge clk);
        check("t6_coef_ready", 64'(bus.coef_ready), 64'd0);
        @(posedge clk);
        #1 bus.coef_we = 1'b0;
        ena = 1'b0;
        repeat (5) @(posedge clk);
        #1 ena = 1'b1;
        wait_out(d, lat);
        check("t6_data", 64'(d), 64'd31);
        check("t6_latency", 64'(lat), 64'd10);
        drain();
        send(0);
        wait_out(d, lat);
        check("t6_coef_kept", 64'(d), 64'd37);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
